program_loader: RTL and testbench

Boot-time instruction loader sitting directly upstream of the single-cycle processor's instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into the instruction memory at consecutive word addresses, and the stream is verified against an XOR checksum. The processor is held in reset until a load completes cleanly.

---
 rtl/program_loader.sv | 109 ++++++++++
 tb/tb_program_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: framed byte-stream boot loader that fills instruction memory, checks an XOR sum, and gates CPU reset.
module program_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [23:0]         lane_q, lane_d;
    logic [1:0]          bidx_q, bidx_d;
    logic [7:0]          csum_q, csum_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                xfer;

    assign in_ready     = rst && (state_q inside {LEN0, LEN1, DATA, CSUM});
    assign xfer         = in_valid && in_ready;
    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = state_q != RUN;
    assign err          = state_q == ERR;
    assign words_loaded = words_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lane_d  = lane_q;
        bidx_d  = bidx_q;
        csum_d  = csum_q;
        words_d = words_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            LEN0: if (xfer) begin
                len_d[7:0] = in_data;
                state_d    = LEN1;
            end
            LEN1: if (xfer) begin
                len_d[15:8] = in_data;
                state_d     = ({1'b0, in_data, len_q[7:0]} > DEPTH) ? ERR :
                              ({in_data, len_q[7:0]} == 16'd0)    ? CSUM : DATA;
            end
            DATA: if (xfer) begin
                csum_d = csum_q ^ in_data;
                bidx_d = bidx_q + 2'd1;
                lane_d = {in_data, lane_q[23:8]};
                // Fourth byte completes the word; earlier bytes sit in the lane register low-byte first
                if (bidx_q == 2'd3) begin
                    we_d    = 1'b1;
                    waddr_d = words_q[ADDR_W-1:0];
                    wdata_d = {in_data, lane_q};
                    words_d = words_q + 1'b1;
                    state_d = (17'(words_q) + 17'd1 == {1'b0, len_q}) ? CSUM : DATA;
                end
            end
            CSUM: if (xfer) state_d = (in_data == csum_q) ? RUN : ERR;
            RUN, ERR: if (reload) begin
                state_d = LEN0;
                words_d = '0;
                bidx_d  = '0;
                csum_d  = '0;
            end
            default: state_d = LEN0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LEN0;
            len_q   <= '0;
            lane_q  <= '0;
            bidx_q  <= '0;
            csum_q  <= '0;
            words_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lane_q  <= lane_d;
            bidx_q  <= bidx_d;
            csum_q  <= csum_d;
            words_q <= words_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives two loaders (256-word and 4-word memories) from one stream and checks them against a frame-level model.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        reload = 1'b0;

    logic        rdy_a, we_a, hold_a, err_a;
    logic [7:0]  wa_a;
    logic [31:0] wd_a;
    logic [8:0]  wl_a;
    logic        rdy_b, we_b, hold_b, err_b;
    logic [1:0]  wa_b;
    logic [31:0] wd_b;
    logic [2:0]  wl_b;

    program_loader #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
        .reload(reload), .imem_we(we_a), .imem_waddr(wa_a), .imem_wdata(wd_a),
        .cpu_hold(hold_a), .err(err_a), .words_loaded(wl_a)
    );

    program_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
        .reload(reload), .imem_we(we_b), .imem_waddr(wa_b), .imem_wdata(wd_b),
        .cpu_hold(hold_b), .err(err_b), .words_loaded(wl_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the bytes accepted in the current frame determine every output.
    int          dp[2] = '{256, 4};
    logic [7:0]  fb[2][1100];
    int          cnt[2] = '{0, 0};
    bit          wexp[2] = '{0, 0};
    int          waddr_e[2];
    logic [31:0] wdata_e[2];
    bit          live = 0;

    function automatic int flen(int m);
        return int'({fb[m][1], fb[m][0]});
    endfunction

    // 0 = still loading, 1 = loaded cleanly, 2 = failed
    function automatic int st(int m);
        int n;
        logic [7:0] x;
        if (cnt[m] < 2) return 0;
        n = flen(m);
        if (n > dp[m]) return 2;
        if (cnt[m] < 3 + 4 * n) return 0;
        x = 8'h00;
        for (int i = 2; i < 2 + 4 * n; i++) x ^= fb[m][i];
        return (fb[m][2 + 4 * n] == x) ? 1 : 2;
    endfunction

    function automatic int wl(int m);
        int n;
        if (cnt[m] < 2) return 0;
        n = flen(m);
        if (n > dp[m]) return 0;
        return ((cnt[m] - 2) / 4 < n) ? (cnt[m] - 2) / 4 : n;
    endfunction

    initial forever begin
        @(posedge clk);
        live = 1;
        for (int m = 0; m < 2; m++) begin
            int s, k;
            s = st(m);
            wexp[m] = 0;
            if (!rst) cnt[m] = 0;
            else if (s != 0 && reload) cnt[m] = 0;
            else if (s == 0 && in_valid) begin
                fb[m][cnt[m]] = in_data;
                cnt[m]++;
                k = (cnt[m] - 2) / 4;
                if (cnt[m] >= 6 && (cnt[m] - 2) % 4 == 0 && k <= flen(m)) begin
                    wexp[m] = 1;
                    waddr_e[m] = k - 1;
                    wdata_e[m] = {fb[m][4*k+1], fb[m][4*k], fb[m][4*k-1], fb[m][4*k-2]};
                end
            end
        end
    end

    logic [31:0] mem_a[256];
    logic [31:0] mem_b[4];
    int nwr_a = 0;
    int nwr_b = 0;

    task automatic cmp(input int m, input logic rdy, input logic we, input logic [31:0] wa,
                       input logic [31:0] wd, input logic hold, input logic er, input logic [31:0] w);
        int s;
        s = st(m);
        chk($sformatf("d%0d.in_ready", m), 32'(rdy), 32'(rst && s == 0));
        chk($sformatf("d%0d.imem_we", m), 32'(we), 32'(wexp[m]));
        chk($sformatf("d%0d.cpu_hold", m), 32'(hold), 32'(s != 1));
        chk($sformatf("d%0d.err", m), 32'(er), 32'(s == 2));
        chk($sformatf("d%0d.words_loaded", m), w, 32'(wl(m)));
        if (wexp[m]) begin
            chk($sformatf("d%0d.imem_waddr", m), wa, 32'(waddr_e[m]));
            chk($sformatf("d%0d.imem_wdata", m), wd, wdata_e[m]);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (live) begin
            cmp(0, rdy_a, we_a, 32'(wa_a), wd_a, hold_a, err_a, 32'(wl_a));
            cmp(1, rdy_b, we_b, 32'(wa_b), wd_b, hold_b, err_b, 32'(wl_b));
            if (we_a) begin mem_a[wa_a] = wd_a; nwr_a++; end
            if (we_b) begin mem_b[wa_b] = wd_b; nwr_b++; end
        end
    end

    logic [7:0] fr[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit rl);
        in_valid = 1'b0;
        reload = rl;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data = b;
        tick();
        in_valid = 1'b0;
        reload = 1'b0;
    endtask

    task automatic send_fr(input bit gaps);
        foreach (fr[i])
            send(fr[i], gaps ? int'($urandom_range(0, 2)) : 0, gaps && i >= 2 && i < fr.size() - 1);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    initial begin
        int base;
        #1;
        repeat (2) tick();
        chk("reset.in_ready", 32'(rdy_a), 32'd0);
        chk("reset.imem_we", 32'(we_a), 32'd0);
        chk("reset.imem_waddr", 32'(wa_a), 32'd0);
        chk("reset.imem_wdata", wd_a, 32'd0);
        chk("reset.cpu_hold", 32'(hold_a), 32'd1);
        chk("reset.err", 32'(err_a), 32'd0);
        chk("reset.words_loaded", 32'(wl_a), 32'd0);
        rst = 1'b1;
        #1;
        chk("post_reset.in_ready", 32'(rdy_a), 32'd1);
        tick();

        fr = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h44};
        send_fr(0);
        chk("good.writes", 32'(nwr_a), 32'd2);
        chk("good.word0", mem_a[0], 32'h11223344);
        chk("good.word1", mem_a[1], 32'hA5A5A5A5);
        chk("good.words_loaded", 32'(wl_a), 32'd2);
        chk("good.cpu_hold", 32'(hold_a), 32'd0);
        chk("good.err", 32'(err_a), 32'd0);
        send(8'h77, 0, 0);
        pulse_reload();
        chk("reload.in_ready", 32'(rdy_a), 32'd1);
        chk("reload.cpu_hold", 32'(hold_a), 32'd1);

        fr[10] = 8'h00;
        send_fr(0);
        chk("bad.err", 32'(err_a), 32'd1);
        chk("bad.cpu_hold", 32'(hold_a), 32'd1);
        chk("bad.in_ready", 32'(rdy_a), 32'd0);
        send(8'h55, 1, 0);
        pulse_reload();
        chk("bad_reload.err", 32'(err_a), 32'd0);
        chk("bad_reload.words_loaded", 32'(wl_a), 32'd0);

        base = nwr_a;
        fr = '{8'h00, 8'h00, 8'h00};
        send_fr(0);
        chk("n0.cpu_hold", 32'(hold_a), 32'd0);
        chk("n0.writes", 32'(nwr_a - base), 32'd0);
        pulse_reload();
        fr = '{8'h00, 8'h00, 8'h01};
        send_fr(0);
        chk("n0bad.err", 32'(err_a), 32'd1);
        pulse_reload();

        base = nwr_b;
        send(8'h05, 0, 0);
        send(8'h00, 0, 0);
        chk("n5.small_err", 32'(err_b), 32'd1);
        chk("n5.big_err", 32'(err_a), 32'd0);
        for (int i = 0; i < 20; i++) send(8'(i), 0, 0);
        send(8'h00, 0, 0);
        chk("n5.small_writes", 32'(nwr_b - base), 32'd0);
        chk("n5.big_words", 32'(wl_a), 32'd5);
        chk("n5.big_hold", 32'(hold_a), 32'd0);
        pulse_reload();
        send(8'h04, 0, 0);
        send(8'h00, 0, 0);
        for (int i = 0; i < 16; i++) send(8'(i), 0, 0);
        send(8'h00, 0, 0);
        chk("n4.small_writes", 32'(nwr_b - base), 32'd4);
        chk("n4.small_words", 32'(wl_b), 32'd4);
        chk("n4.small_word3", mem_b[3], 32'h0F0E0D0C);
        chk("n4.small_hold", 32'(hold_b), 32'd0);
        pulse_reload();

        mem_a[0] = '0;
        mem_a[1] = '0;
        fr = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h44};
        send_fr(1);
        chk("gaps.word0", mem_a[0], 32'h11223344);
        chk("gaps.word1", mem_a[1], 32'hA5A5A5A5);
        chk("gaps.cpu_hold", 32'(hold_a), 32'd0);
        pulse_reload();

        base = nwr_a;
        for (int i = 0; i < 8; i++) send(fr[i], 0, 0);
        chk("abort.writes", 32'(nwr_a - base), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort.in_ready", 32'(rdy_a), 32'd0);
        tick();
        chk("abort.imem_we", 32'(we_a), 32'd0);
        chk("abort.words_loaded", 32'(wl_a), 32'd0);
        chk("abort.imem_wdata", wd_a, 32'd0);
        chk("abort.cpu_hold", 32'(hold_a), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort.late_writes", 32'(nwr_a - base), 32'd1);
        mem_a[0] = '0;
        send_fr(0);
        chk("fresh.word0", mem_a[0], 32'h11223344);
        chk("fresh.words_loaded", 32'(wl_a), 32'd2);
        chk("fresh.cpu_hold", 32'(hold_a), 32'd0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
